// File: rtl/tdm_demux4.sv
// tdm_demux4: receive side of a time-division-multiplexed channel path.
// Reassembles CH channel words of W bits each from one serial stream in which
// the channel slots follow each other, MSB first. frame_sync marks the first
// bit of every frame. Whole frames are published on ch_data together with a
// one-cycle frame_valid pulse. Misplaced or missing syncs raise a one-cycle
// sync_err pulse.
module tdm_demux4 #(
  parameter  int CH  = 4,                        // channels (slots) per frame, >= 2
  parameter  int W   = 8,                        // bits per slot, >= 2
  localparam int SW  = (CH > 1) ? $clog2(CH) : 1, // slot index width
  localparam int BW  = (W > 1) ? $clog2(W) : 1    // bit counter width
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            en,
  input  logic            din,
  input  logic            frame_sync,
  output logic [CH*W-1:0] ch_data,
  output logic            frame_valid,
  output logic            sync_err,
  output logic [SW-1:0]   slot
);

  // The shift register only has to hold the bits that arrived before the
  // current one; the last bit of a word is taken straight from din.
  localparam int SRW = W - 1;

  localparam logic [BW-1:0] BIT_ONE   = BW'(1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(W - 1);
  localparam logic [SW-1:0] SLOT_LAST = SW'(CH - 1);

  // HUNT  : waiting for any sync to lock on.
  // RUN   : inside a frame, counting bits and slots.
  // CHECK : a frame just ended, the next strobed bit must carry a sync.
  typedef enum logic [1:0] {
    HUNT  = 2'd0,
    RUN   = 2'd1,
    CHECK = 2'd2
  } state_t;

  state_t          state;
  state_t          next_state;

  logic [BW-1:0]   bit_cnt;
  logic [SRW-1:0]  shreg;
  logic [W-1:0]    staging [CH-1];   // words of slots 0..CH-2 of the frame in flight
  logic [W-1:0]    cur_word;
  logic [CH*W-1:0] frame_word;

  // Control strobes produced by the FSM for the datapath.
  logic            start_frame;      // this bit is bit 0 of a new frame
  logic            shift_bit;        // this bit continues the current frame
  logic            word_done;        // this bit completes a slot
  logic            frame_done;       // this bit completes the last slot
  logic            err;              // alignment error seen on this bit

  // The word as it will look once the bit on din is appended.
  assign cur_word   = {shreg, din};
  assign word_done  = shift_bit && (bit_cnt == BIT_LAST);
  assign frame_done = word_done && (slot == SLOT_LAST);

  // State register.
  // NOTE: every clocked process uses non-blocking assignments so that all
  // registers update together from values sampled before the edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= HUNT;
    end else begin
      state <= next_state;
    end
  end

  // Next-state decode and datapath control strobes.
  // NOTE: every output of this block gets a default first, so no path can
  // leave a signal unassigned and infer a latch.
  always_comb begin
    next_state  = state;
    start_frame = 1'b0;
    shift_bit   = 1'b0;
    err         = 1'b0;
    unique case (state)
      HUNT: begin
        // Bits without sync carry no alignment and are dropped.
        if (en && frame_sync) begin
          start_frame = 1'b1;
          next_state  = RUN;
        end
      end
      RUN: begin
        if (en) begin
          if (frame_sync) begin
            // Sync in the middle of a frame: resynchronise on this bit.
            err         = 1'b1;
            start_frame = 1'b1;
          end else begin
            shift_bit = 1'b1;
            if ((bit_cnt == BIT_LAST) && (slot == SLOT_LAST)) begin
              next_state = CHECK;
            end
          end
        end
      end
      CHECK: begin
        if (en) begin
          if (frame_sync) begin
            start_frame = 1'b1;
            next_state  = RUN;
          end else begin
            // Expected sync missing: lose lock and drop the bit.
            err        = 1'b1;
            next_state = HUNT;
          end
        end
      end
      default: begin
        next_state = HUNT;
      end
    endcase
  end

  // Full frame image: completed staging words plus the word finishing now.
  always_comb begin
    frame_word = '0;
    for (int k = 0; k < CH - 1; k++) begin
      frame_word[k*W +: W] = staging[k];
    end
    frame_word[(CH-1)*W +: W] = cur_word;
  end

  // Bit/slot counters, shift register, published frame and status pulses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bit_cnt     <= '0;
      slot        <= '0;
      shreg       <= '0;
      ch_data     <= '0;
      frame_valid <= 1'b0;
      sync_err    <= 1'b0;
    end else begin
      // Pulses last exactly one cycle; idle cycles clear them.
      frame_valid <= frame_done;
      sync_err    <= err;
      if (start_frame) begin
        shreg   <= SRW'(din);
        bit_cnt <= BIT_ONE;
        slot    <= '0;
      end else if (shift_bit) begin
        shreg <= SRW'({shreg, din});
        if (word_done) begin
          bit_cnt <= '0;
          if (frame_done) begin
            slot    <= '0;
            ch_data <= frame_word;
          end else begin
            slot <= slot + 1'b1;
          end
        end else begin
          bit_cnt <= bit_cnt + 1'b1;
        end
      end
    end
  end

  // Staging words for slots 0..CH-2; the last slot goes straight to ch_data.
  // NOTE: this storage has no reset; a frame is only published after every
  // staging entry has been rewritten within that same frame, so stale
  // contents can never reach ch_data.
  always_ff @(posedge clk) begin
    if (word_done && !frame_done) begin
      staging[slot] <= cur_word;
    end
  end

endmodule

// File: tb/tb_tdm_demux4.sv
// tb_tdm_demux4: self-checking bench for tdm_demux4 (CH=4, W=8).
// A frame-level reference model (one position counter over the whole frame,
// frames assembled arithmetically from the received bit list) predicts every
// output after every clock; directed scenarios add checks on pulse counts,
// pulse timing and the published words.
module tb_tdm_demux4;

  localparam int CH = 4;
  localparam int W  = 8;
  localparam int FB = CH * W;
  localparam int SW = $clog2(CH);
  localparam int VW = FB + 2 + SW;

  logic          clk = 1'b0;
  logic          rst;
  logic          en;
  logic          din;
  logic          frame_sync;
  logic [FB-1:0] ch_data;
  logic          frame_valid;
  logic          sync_err;
  logic [SW-1:0] slot;

  tdm_demux4 #(.CH(CH), .W(W)) dut (
    .clk         (clk),
    .rst         (rst),
    .en          (en),
    .din         (din),
    .frame_sync  (frame_sync),
    .ch_data     (ch_data),
    .frame_valid (frame_valid),
    .sync_err    (sync_err),
    .slot        (slot)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic en;
    logic din;
    logic sync;
  } stim_t;

  typedef enum int {M_HUNT, M_RUN, M_CHECK} mmode_t;

  // Reference model state.
  mmode_t        m_mode;
  int            m_pos;            // bits of the current frame received so far
  logic          m_bits [FB];      // frame bits in arrival order
  logic [FB-1:0] m_ch;
  logic          m_fv;
  logic          m_se;

  stim_t         stim [$];
  int            gap_ctr;
  int            checks   = 0;
  int            failures = 0;

  // Frame image from the arrival-ordered bit list: slot k, MSB first.
  function automatic logic [FB-1:0] assemble();
    logic [FB-1:0] r;
    r = '0;
    for (int i = 0; i < FB; i++) begin
      r[(i / W) * W + (W - 1 - (i % W))] = m_bits[i];
    end
    return r;
  endfunction

  function automatic void model_reset();
    m_mode = M_HUNT;
    m_pos  = 0;
    m_ch   = '0;
    m_fv   = 1'b0;
    m_se   = 1'b0;
  endfunction

  function automatic void model_start(input logic d);
    m_bits[0] = d;
    m_pos     = 1;
    m_mode    = M_RUN;
  endfunction

  function automatic void model_step(input logic e, input logic d, input logic s);
    m_fv = 1'b0;
    m_se = 1'b0;
    if (e) begin
      case (m_mode)
        M_HUNT: if (s) model_start(d);
        M_RUN: begin
          if (s) begin
            m_se = 1'b1;
            model_start(d);
          end else begin
            m_bits[m_pos] = d;
            m_pos++;
            if (m_pos == FB) begin
              m_ch   = assemble();
              m_fv   = 1'b1;
              m_pos  = 0;
              m_mode = M_CHECK;
            end
          end
        end
        default: begin
          if (s) begin
            model_start(d);
          end else begin
            m_se   = 1'b1;
            m_mode = M_HUNT;
          end
        end
      endcase
    end
  endfunction

  function automatic logic [VW-1:0] expv();
    logic [SW-1:0] es;
    es = (m_mode == M_RUN) ? SW'(m_pos / W) : '0;
    return {m_ch, m_fv, m_se, es};
  endfunction

  function automatic logic [VW-1:0] got();
    return {ch_data, frame_valid, sync_err, slot};
  endfunction

  // Queue nbits of a frame (bit 0 carries sync); every gap-th cycle is idle
  // with random din/sync that must be ignored.
  function automatic void push_frame(input logic [FB-1:0] frame, input int gap, input int nbits);
    for (int i = 0; i < nbits; i++) begin
      if (gap > 0 && (gap_ctr % gap) == gap - 1) begin
        stim.push_back('{1'b0, 1'($urandom), 1'($urandom)});
        gap_ctr++;
      end
      stim.push_back('{1'b1, frame[(i / W) * W + (W - 1 - (i % W))], (i == 0)});
      gap_ctr++;
    end
  endfunction

  function automatic void push_idle(input int n);
    for (int i = 0; i < n; i++) stim.push_back('{1'b0, 1'($urandom), 1'($urandom)});
  endfunction

  function automatic void push_junk(input int n);
    for (int i = 0; i < n; i++) stim.push_back('{1'($urandom), 1'($urandom), 1'b0});
  endfunction

  // Apply one cycle of stimulus, advance the model, sample after the edge.
  task automatic tick(input stim_t s);
    en         = s.en;
    din        = s.din;
    frame_sync = s.sync;
    model_step(s.en, s.din, s.sync);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; en = 1'b0; din = 1'b0; frame_sync = 1'b0;
    model_reset();
    #2;
    checks++;
    if (got() !== '0) begin
      failures++;
      $display("FAIL reset_outputs got=%h want=0", got());
    end
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
    tick('{1'b0, 1'b0, 1'b0});
    checks++;
    if (got() !== expv()) begin
      failures++;
      $display("FAIL reset_idle got=%h want=%h", got(), expv());
    end
  endtask

  task automatic test_single_frame();
    int nfv = 0, nse = 0, fv_at = -1;
    stim.delete(); gap_ctr = 0;
    push_frame(32'hD4C3B2A1, 0, FB);
    push_idle(3);
    foreach (stim[i]) begin
      tick(stim[i]);
      checks++;
      if (got() !== expv()) begin
        failures++;
        $display("FAIL single_cycle%0d got=%h want=%h", i, got(), expv());
      end
      if (frame_valid) begin nfv++; fv_at = i; end
      if (sync_err) nse++;
    end
    checks++;
    if (nfv !== 1 || fv_at !== FB - 1) begin
      failures++;
      $display("FAIL single_valid count=%0d at=%0d want count=1 at=%0d", nfv, fv_at, FB - 1);
    end
    checks++;
    if (nse !== 0) begin
      failures++;
      $display("FAIL single_syncerr count=%0d want=0", nse);
    end
    checks++;
    if (ch_data !== 32'hD4C3B2A1) begin
      failures++;
      $display("FAIL single_data got=%h want=d4c3b2a1", ch_data);
    end
  endtask

  task automatic test_back_to_back();
    int nfv = 0, first = -1, second = -1;
    stim.delete(); gap_ctr = 0;
    push_frame(32'hD4C3B2A1, 0, FB);
    push_frame(32'h44332211, 0, FB);
    push_idle(2);
    foreach (stim[i]) begin
      tick(stim[i]);
      checks++;
      if (got() !== expv()) begin
        failures++;
        $display("FAIL b2b_cycle%0d got=%h want=%h", i, got(), expv());
      end
      if (frame_valid) begin
        nfv++;
        if (first < 0) first = i; else second = i;
      end
    end
    checks++;
    if (nfv !== 2 || second - first !== FB) begin
      failures++;
      $display("FAIL b2b_valid count=%0d spacing=%0d want count=2 spacing=%0d", nfv, second - first, FB);
    end
    checks++;
    if (ch_data !== 32'h44332211) begin
      failures++;
      $display("FAIL b2b_data got=%h want=44332211", ch_data);
    end
  endtask

  task automatic test_en_gaps();
    int nfv = 0, en_bits = 0, fv_after = -1;
    stim.delete(); gap_ctr = 0;
    push_frame(32'hD4C3B2A1, 3, FB);
    push_idle(2);
    foreach (stim[i]) begin
      tick(stim[i]);
      if (stim[i].en) en_bits++;
      checks++;
      if (got() !== expv()) begin
        failures++;
        $display("FAIL gaps_cycle%0d got=%h want=%h", i, got(), expv());
      end
      if (frame_valid) begin nfv++; fv_after = en_bits; end
    end
    checks++;
    if (nfv !== 1 || fv_after !== FB || ch_data !== 32'hD4C3B2A1) begin
      failures++;
      $display("FAIL gaps_frame count=%0d after_bits=%0d data=%h want 1/%0d/d4c3b2a1", nfv, fv_after, ch_data, FB);
    end
  endtask

  task automatic test_mid_frame_sync();
    int nfv = 0, nse = 0;
    stim.delete(); gap_ctr = 0;
    push_frame(32'h0BADF00D, 0, 13);
    push_frame(32'h88776655, 0, FB);
    push_idle(2);
    foreach (stim[i]) begin
      tick(stim[i]);
      checks++;
      if (got() !== expv()) begin
        failures++;
        $display("FAIL midsync_cycle%0d got=%h want=%h", i, got(), expv());
      end
      if (i < 13 + FB - 1 && ch_data !== 32'hD4C3B2A1) begin
        checks++;
        failures++;
        $display("FAIL midsync_hold cycle%0d got=%h want=d4c3b2a1", i, ch_data);
      end
      if (frame_valid) nfv++;
      if (sync_err) nse++;
    end
    checks++;
    if (nse !== 1 || nfv !== 1 || ch_data !== 32'h88776655) begin
      failures++;
      $display("FAIL midsync_result err=%0d valid=%0d data=%h want 1/1/88776655", nse, nfv, ch_data);
    end
  endtask

  task automatic test_missing_sync();
    int nfv = 0, nse = 0;
    stim.delete(); gap_ctr = 0;
    push_frame(32'hCAFEF00D, 0, FB);
    stim.push_back('{1'b1, 1'b1, 1'b0});
    push_junk(20);
    push_frame(32'h5A5AA5A5, 0, FB);
    push_idle(2);
    foreach (stim[i]) begin
      tick(stim[i]);
      checks++;
      if (got() !== expv()) begin
        failures++;
        $display("FAIL nosync_cycle%0d got=%h want=%h", i, got(), expv());
      end
      if (frame_valid) nfv++;
      if (sync_err) nse++;
    end
    checks++;
    if (nse !== 1 || nfv !== 2 || ch_data !== 32'h5A5AA5A5) begin
      failures++;
      $display("FAIL nosync_result err=%0d valid=%0d data=%h want 1/2/5a5aa5a5", nse, nfv, ch_data);
    end
  endtask

  task automatic test_async_reset();
    int nfv = 0;
    stim.delete(); gap_ctr = 0;
    push_frame(32'h13579BDF, 0, 20);
    foreach (stim[i]) tick(stim[i]);
    // Assert reset between clock edges: outputs must clear without an edge.
    #2;
    rst = 1'b1;
    en  = 1'b0;
    #1;
    model_reset();
    checks++;
    if (got() !== '0) begin
      failures++;
      $display("FAIL async_reset got=%h want=0", got());
    end
    @(posedge clk); #1;
    rst = 1'b0;
    stim.delete(); gap_ctr = 0;
    // The interrupted frame's remaining bits arrive without sync and must vanish.
    push_junk(12);
    push_frame(32'h2468ACE0, 0, FB);
    push_idle(2);
    foreach (stim[i]) begin
      tick(stim[i]);
      checks++;
      if (got() !== expv()) begin
        failures++;
        $display("FAIL rstframe_cycle%0d got=%h want=%h", i, got(), expv());
      end
      if (frame_valid) nfv++;
    end
    checks++;
    if (nfv !== 1 || ch_data !== 32'h2468ACE0) begin
      failures++;
      $display("FAIL rstframe_result valid=%0d data=%h want 1/2468ace0", nfv, ch_data);
    end
  endtask

  task automatic test_random();
    int nfv = 0;
    stim.delete(); gap_ctr = 0;
    for (int n = 0; n < 60; n++) begin
      case ($urandom_range(0, 5))
        0, 1, 2: push_frame(FB'($urandom), ($urandom_range(0, 1) == 0) ? 0 : $urandom_range(2, 5), FB);
        3:       push_frame(FB'($urandom), 0, $urandom_range(1, FB - 1));
        4:       push_junk($urandom_range(1, 10));
        default: push_idle($urandom_range(1, 4));
      endcase
    end
    foreach (stim[i]) begin
      tick(stim[i]);
      checks++;
      if (got() !== expv()) begin
        failures++;
        $display("FAIL random_cycle%0d got=%h want=%h", i, got(), expv());
      end
      if (frame_valid) nfv++;
    end
    checks++;
    if (nfv == 0) begin
      failures++;
      $display("FAIL random_activity valid_pulses=%0d want>0", nfv);
    end
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_back_to_back();
    test_en_gaps();
    test_mid_frame_sync();
    test_missing_sync();
    test_async_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
